// File: rtl/softmax_lane_scheduler.sv
// softmax_lane_scheduler: routes whole tile rows round-robin to softmax lanes, tracks busy/done and signals completed row groups
module softmax_lane_scheduler #(
  parameter int WIDTH     = 16,
  parameter int TILE_SIZE = 8,
  parameter int COL       = 64,
  parameter int NUM_LANES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH*TILE_SIZE-1:0]   in_tile,
  output logic [WIDTH*TILE_SIZE-1:0]   lane_tile,
  output logic [NUM_LANES-1:0]         lane_valid,
  output logic                         lane_first,
  output logic                         lane_last,
  input  logic [NUM_LANES-1:0]         lane_done,
  output logic [NUM_LANES-1:0]         lane_clr,
  output logic                         group_valid,
  output logic [15:0]                  group_count,
  output logic [1:0]                   sched_state,
  output logic                         err_done
);
  localparam int NUM_TILES = COL / TILE_SIZE;
  localparam int LW = $clog2(NUM_LANES);
  localparam int TW = $clog2(NUM_TILES);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, STALL = 2'd2} state_t;

  state_t               state;
  logic [LW-1:0]        lane_ptr, ptr_n;
  logic [TW-1:0]        tile_cnt;
  logic [NUM_LANES-1:0] busy, busy_n, done_mask, mask_n, done_ok, set_mask, ptr_oh;
  logic                 accept, row_end;

  assign in_ready    = !busy[lane_ptr];
  assign accept      = in_valid && in_ready;
  assign row_end     = accept && tile_cnt == TW'(NUM_TILES - 1);
  assign ptr_oh      = NUM_LANES'(1) << lane_ptr;
  // a done only counts for a lane already busy, so a same-cycle busy set always wins
  assign done_ok     = lane_done & busy;
  assign set_mask    = row_end ? ptr_oh : '0;
  assign busy_n      = (busy & ~done_ok) | set_mask;
  assign mask_n      = done_mask | done_ok;
  assign ptr_n       = row_end ? lane_ptr + LW'(1) : lane_ptr;
  assign sched_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lane_ptr    <= '0;
      tile_cnt    <= '0;
      busy        <= '0;
      done_mask   <= '0;
      lane_tile   <= '0;
      lane_valid  <= '0;
      lane_first  <= 1'b0;
      lane_last   <= 1'b0;
      lane_clr    <= '0;
      group_valid <= 1'b0;
      group_count <= '0;
      err_done    <= 1'b0;
    end else begin
      if (accept) lane_tile <= in_tile;
      lane_valid  <= accept ? ptr_oh : '0;
      lane_first  <= accept && tile_cnt == '0;
      lane_last   <= row_end;
      tile_cnt    <= row_end ? '0 : accept ? tile_cnt + TW'(1) : tile_cnt;
      lane_ptr    <= ptr_n;
      busy        <= busy_n;
      lane_clr    <= done_ok;
      group_valid <= &mask_n;
      done_mask   <= &mask_n ? '0 : mask_n;
      group_count <= &mask_n ? group_count + 16'd1 : group_count;
      err_done    <= err_done | |(lane_done & ~busy);
      case (state)
        IDLE:    state <= accept ? STREAM : IDLE;
        STREAM:  state <= busy_n[ptr_n] ? STALL :
                          (tile_cnt == '0 && busy == '0 && !accept) ? IDLE : STREAM;
        STALL:   state <= busy_n[lane_ptr] ? STALL : STREAM;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
